// File: rtl/lm07_pkg.sv
// ---------------------------------------------------------------------------
// lm07_pkg
// Shared types and constants for the LM07/LM70 SPI read sequencer.
//   lm07_state_e  : sequencer FSM states
//   FRAME_BITS    : bits per sensor frame, read MSB-first
//   TEMP_INT_*    : slice of the raw frame that holds integer degC
//   TAIL_MASK     : value the frame tail must carry on a good read
// ---------------------------------------------------------------------------
package lm07_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } lm07_state_e;

    localparam int FRAME_BITS   = 16;
    localparam int BIT_CNT_W    = $clog2(FRAME_BITS);
    localparam int TEMP_INT_MSB = 15;
    localparam int TEMP_INT_LSB = 7;
    localparam int TAIL_BITS    = 5;
    localparam logic [TAIL_BITS-1:0] TAIL_MASK = 5'b11111;

endpackage

// File: rtl/lm07_sck_div.sv
// ---------------------------------------------------------------------------
// lm07_sck_div
// Half-period timer for the sensor serial clock. A down-counter runs
// CLK_DIV-1..0 and reloads itself, so every phase lasts CLK_DIV cycles.
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   restart    in   realign the phase to the current cycle (frame start)
//   sck_level  in   current sck level, used to qualify the sample strobe
//   phase_end  out  last cycle of the current half-period
//   sample_en  out  last cycle of a high half-period (sio capture point)
// ---------------------------------------------------------------------------
module lm07_sck_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic sck_level,
    output logic phase_end,
    output logic sample_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (restart || cnt == '0) begin
            cnt <= LOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_end = (cnt == '0);
    // The sensor moves sio on the sck fall, so the end of the high phase
    // is the most settled point to capture it.
    assign sample_en = phase_end & sck_level;

endmodule

// File: rtl/lm07_sample_ctrl.sv
// ---------------------------------------------------------------------------
// lm07_sample_ctrl
// SPI read sequencer for an LM07/LM70-family temperature sensor. Runs
// one-shot or periodic conversions, reads a 16-bit frame MSB-first, checks
// the tail, converts to integer degC and drives a hysteretic alarm.
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active low
//   en          in   continuous sampling enable (level)
//   trig        in   one-shot request (1-cycle pulse)
//   sio         in   sensor serial data
//   cs_n        out  sensor chip select, active low
//   sck         out  serial clock, idles low
//   busy        out  high from cs_n fall until data_valid
//   data_valid  out  1-cycle frame-complete pulse
//   frame_err   out  1-cycle pulse with data_valid on a bad tail
//   temp_raw    out  last raw frame
//   temp_c      out  signed degC of the last good frame
//   alarm       out  over-temperature flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | cs_n high, waiting for trig, pending or a periodic slot
// ST_SETUP | cs_n low, sck low for one half-period before the first bit
// ST_SHIFT | 16 sck periods; sio captured at the end of each high phase
// ST_HOLD  | sck low for one half-period, then cs_n released
// ST_GAP   | cs_n high; results published on the first cycle
// ---------------------------------------------------------------------------
module lm07_sample_ctrl
    import lm07_pkg::*;
#(
    parameter int               CLK_DIV       = 2,
    parameter int               SAMPLE_PERIOD = 1000,
    parameter logic signed [8:0] T_HIGH       = 9'sd40,
    parameter logic signed [8:0] T_LOW        = 9'sd35
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   trig,
    input  logic                   sio,
    output logic                   cs_n,
    output logic                   sck,
    output logic                   busy,
    output logic                   data_valid,
    output logic                   frame_err,
    output logic [FRAME_BITS-1:0]  temp_raw,
    output logic signed [8:0]      temp_c,
    output logic                   alarm
);

    localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int GW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [PW-1:0] PERIOD_LOAD = PW'(SAMPLE_PERIOD - 1);
    // cs_n stays high for GAP plus the IDLE cycle, so GAP itself is one
    // cycle short of the 2*CLK_DIV minimum.
    localparam logic [GW-1:0] GAP_LOAD    = GW'(2 * CLK_DIV - 2);

    lm07_state_e           state;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [PW-1:0]         period_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  pending;
    logic                  start;
    logic                  phase_end;
    logic                  sample_en;
    logic signed [8:0]     new_temp;
    logic                  tail_ok;

    assign start    = (state == ST_IDLE) && (trig || pending || (en && period_cnt == '0));
    assign new_temp = shift_reg[TEMP_INT_MSB:TEMP_INT_LSB];
    assign tail_ok  = (shift_reg[TAIL_BITS-1:0] == TAIL_MASK);

    lm07_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (start),
        .sck_level (sck),
        .phase_end (phase_end),
        .sample_en (sample_en)
    );

    // Period timer: reloads on every start so periodic frames are spaced
    // from the last start of any kind. Held at zero while en is low so a
    // rising en starts a frame on the next IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (start) begin
            period_cnt <= PERIOD_LOAD;
        end else if (!en) begin
            period_cnt <= '0;
        end else if (period_cnt != '0) begin
            period_cnt <= period_cnt - PW'(1);
        end
    end

    // A trig that coincides with a start is consumed by that start, so it
    // never leaves a pending frame behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (start) begin
            pending <= 1'b0;
        end else if (trig) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cs_n       <= 1'b1;
            sck        <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            temp_raw   <= '0;
            temp_c     <= '0;
            alarm      <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            gap_cnt    <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        sck   <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sample_en) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], sio};
                        sck       <= 1'b0;
                    end else if (phase_end) begin
                        if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            sck     <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        cs_n    <= 1'b1;
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LOAD) begin
                        data_valid <= 1'b1;
                        busy       <= 1'b0;
                        temp_raw   <= shift_reg;
                        if (tail_ok) begin
                            temp_c <= new_temp;
                            if (new_temp >= T_HIGH) begin
                                alarm <= 1'b1;
                            end else if (new_temp < T_LOW) begin
                                alarm <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                    sck   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm07_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lm07_sample_ctrl
// Self-checking bench for lm07_sample_ctrl with a behavioural LM07 sensor
// and a frame-level reference model of conversion and alarm hysteresis.
// ---------------------------------------------------------------------------
module tb_lm07_sample_ctrl;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 200;
    localparam int T_HIGH_C      = 40;
    localparam int T_LOW_C       = 35;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              trig;
    logic              sio;
    logic              cs_n;
    logic              sck;
    logic              busy;
    logic              data_valid;
    logic              frame_err;
    logic [15:0]       temp_raw;
    logic signed [8:0] temp_c;
    logic              alarm;

    lm07_sample_ctrl #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .T_HIGH        (9'sd40),
        .T_LOW         (9'sd35)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .trig       (trig),
        .sio        (sio),
        .cs_n       (cs_n),
        .sck        (sck),
        .busy       (busy),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .temp_raw   (temp_raw),
        .temp_c     (temp_c),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int floor_div128(input int v);
        int q;
        q = v / 128;
        if (v < 0 && q * 128 != v) q--;
        return q;
    endfunction

    // Behavioural sensor: MSB on cs_n fall, next bit after every sck fall.
    logic [15:0] model_word = 16'h0000;
    int          fall_cnt   = 0;

    always @(posedge cs_n or negedge sck) begin
        if (cs_n) fall_cnt = 0;
        else      fall_cnt = fall_cnt + 1;
    end

    always_comb begin
        sio = 1'b0;
        if (fall_cnt < 16) sio = model_word[4'(15 - fall_cnt)];
    end

    // Frame monitor and reference model, sampled on the falling clock edge.
    logic        cs_n_q = 1'b1;
    logic        sck_q  = 1'b0;
    bit          in_frame = 1'b0;
    int          low_cnt = 0;
    int          sck_rises = 0;
    int          rise_time = 0;
    int          dv_cnt = 0;
    int          ferr_cnt = 0;
    int          ferr_alone = 0;
    int          falls[$];
    int          rises[$];
    logic [15:0] exp_q[$];
    int          ref_temp = 0;
    int          ref_alarm = 0;

    always @(negedge clk) begin
        logic [15:0] w;
        int          v;
        if (!rst_n) begin
            ref_temp  = 0;
            ref_alarm = 0;
            in_frame  = 1'b0;
            exp_q.delete();
        end else begin
            if (cs_n_q && !cs_n) begin
                falls.push_back(cyc);
                exp_q.push_back(model_word);
                low_cnt   = 0;
                sck_rises = 0;
                in_frame  = 1'b1;
            end
            if (!cs_n) begin
                low_cnt++;
                if (sck && !sck_q) sck_rises++;
            end
            if (!cs_n_q && cs_n && in_frame) begin
                in_frame  = 1'b0;
                rise_time = cyc;
                rises.push_back(cyc);
                check_val("cs_low_len", low_cnt, 34 * CLK_DIV);
                check_val("sck_rises", sck_rises, 16);
                check_val("busy_at_cs_rise", int'(busy), 1);
            end
            if (frame_err && !data_valid) ferr_alone++;
            if (data_valid) begin
                dv_cnt++;
                if (frame_err) ferr_cnt++;
                check_val("dv_after_cs_rise", cyc - rise_time, 1);
                check_val("exp_q_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    v = int'($signed(w));
                    if (int'(w) % 32 == 31) begin
                        ref_temp = floor_div128(v);
                        if (ref_temp >= T_HIGH_C)     ref_alarm = 1;
                        else if (ref_temp < T_LOW_C)  ref_alarm = 0;
                    end
                    check_val("temp_raw", int'(temp_raw), int'(w));
                    check_val("frame_err", int'(frame_err), (int'(w) % 32 == 31) ? 0 : 1);
                    check_val("temp_c", int'(temp_c), ref_temp);
                    check_val("alarm", int'(alarm), ref_alarm);
                end
            end
        end
        cs_n_q = cs_n;
        sck_q  = sck;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    task automatic wait_dv(input string tag, input int n, input int budget);
        int s;
        int k;
        s = dv_cnt;
        k = 0;
        while (dv_cnt < s + n && k < budget) begin
            tick(1);
            k++;
        end
        check_val(tag, dv_cnt - s, n);
    endtask

    logic [15:0] t4_words  [4];
    int          t4_temps  [4];
    int          t4_alarms [4];

    initial begin
        int n0;
        int r0;
        int d0;
        int t0;
        int k;
        int t;
        int hi;
        int tail;
        bit dbl;

        t4_words  = '{16'h191F, 16'h129F, 16'h111F, 16'hF31F};
        t4_temps  = '{50, 37, 34, -26};
        t4_alarms = '{1, 1, 0, 0};

        // 1: reset and a long idle stretch
        rst_n = 1'b0;
        en    = 1'b0;
        trig  = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(500);
        check_val("idle_cs_n", int'(cs_n), 1);
        check_val("idle_sck", int'(sck), 0);
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_frames", falls.size(), 0);
        check_val("idle_dv", dv_cnt, 0);
        check_val("idle_temp_raw", int'(temp_raw), 0);
        check_val("idle_temp_c", int'(temp_c), 0);
        check_val("idle_alarm", int'(alarm), 0);

        // 2: single triggered frame
        model_word = 16'h191F;
        pulse_trig();
        wait_dv("t2_dv", 1, 200);
        check_val("t2_temp_raw", int'(temp_raw), 16'h191F);
        check_val("t2_temp_c", int'(temp_c), 50);
        check_val("t2_alarm", int'(alarm), 1);
        tick(10);

        // 4: alarm hysteresis sequence
        for (int i = 0; i < 4; i++) begin
            model_word = t4_words[i];
            pulse_trig();
            wait_dv("t4_dv", 1, 200);
            check_val("t4_temp_c", int'(temp_c), t4_temps[i]);
            check_val("t4_alarm", int'(alarm), t4_alarms[i]);
            tick(10);
        end

        // 5: bad tail after a good frame
        model_word = 16'h191F;
        pulse_trig();
        wait_dv("t5_dv_good", 1, 200);
        tick(10);
        n0 = ferr_cnt;
        model_word = 16'h1900;
        pulse_trig();
        wait_dv("t5_dv_bad", 1, 200);
        check_val("t5_ferr_with_dv", ferr_cnt - n0, 1);
        check_val("t5_temp_raw", int'(temp_raw), 16'h1900);
        check_val("t5_temp_c", int'(temp_c), 50);
        check_val("t5_alarm", int'(alarm), 1);
        tick(10);

        // 3: periodic sampling, en dropped in the fourth frame
        model_word = 16'h129F;
        n0 = falls.size();
        d0 = dv_cnt;
        en = 1'b1;
        k  = 0;
        while (falls.size() == n0 && k < 20) begin
            tick(1);
            k++;
        end
        check_val("t3_first_frame", falls.size() - n0, 1);
        if (falls.size() > n0) begin
            t0 = falls[n0];
            while (cyc < t0 + 610) tick(1);
            en = 1'b0;
            tick(400);
            check_val("t3_frames", falls.size() - n0, 4);
            check_val("t3_dv", dv_cnt - d0, 4);
            for (int i = 1; i < 4; i++) begin
                if (falls.size() > n0 + i)
                    check_val("t3_period", falls[n0 + i] - falls[n0 + i - 1], SAMPLE_PERIOD);
            end
        end

        // 6a: reset in mid-frame with a pending trig
        model_word = 16'h191F;
        n0 = falls.size();
        d0 = dv_cnt;
        pulse_trig();
        tick(10);
        pulse_trig();
        check_val("t6_started", falls.size() - n0, 1);
        if (falls.size() > n0) begin
            while (cyc < falls[n0] + 20) tick(1);
        end
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_cs_n", int'(cs_n), 1);
        check_val("t6_rst_sck", int'(sck), 0);
        tick(5);
        rst_n = 1'b1;
        tick(200);
        check_val("t6_no_dv", dv_cnt - d0, 0);
        check_val("t6_no_restart", falls.size() - n0, 1);
        check_val("t6_temp_c_cleared", int'(temp_c), 0);

        // 6b: same without reset; pending frame follows after the minimum gap
        n0 = falls.size();
        r0 = rises.size();
        pulse_trig();
        tick(10);
        pulse_trig();
        tick(10);
        pulse_trig();
        wait_dv("t6_dv_pair", 2, 400);
        tick(100);
        check_val("t6_merged_frames", falls.size() - n0, 2);
        if (falls.size() > n0 + 1 && rises.size() > r0)
            check_val("t6_gap", falls[n0 + 1] - rises[r0], 2 * CLK_DIV);

        // randomized frames, some with a merged second request
        for (int i = 0; i < 25; i++) begin
            t    = int'($urandom_range(0, 100)) - 30;
            hi   = int'($urandom_range(0, 3));
            tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 31;
            model_word = 16'(t * 128 + hi * 32 + tail);
            dbl = ($urandom_range(0, 2) == 0);
            pulse_trig();
            if (dbl) begin
                tick(int'($urandom_range(1, 60)));
                pulse_trig();
            end
            wait_dv("rnd_dv", dbl ? 2 : 1, 400);
            tick(int'($urandom_range(6, 20)));
        end

        tick(20);
        check_val("end_busy", int'(busy), 0);
        check_val("end_cs_n", int'(cs_n), 1);
        check_val("ferr_without_dv", ferr_alone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
